// File: rtl/baw_match_if.sv
// baw_match_if: player inputs and game status bundle for the match engine
interface baw_match_if #(
  parameter int NCARD = 9,
  parameter int NROUND = NCARD
);
  localparam int CW = $clog2(NCARD);
  localparam int RW = $clog2(NROUND + 1);
  logic btn_confirm;
  logic btn_abort;
  logic [NCARD-1:0] sw;
  logic [2:0] state;
  logic [RW-1:0] round;
  logic [RW-1:0] p1_wins;
  logic [RW-1:0] p2_wins;
  logic lead;
  logic [NCARD-1:0] p1_used;
  logic [NCARD-1:0] p2_used;
  logic [CW:0] p1_black_left;
  logic [CW:0] p1_white_left;
  logic [CW:0] p2_black_left;
  logic [CW:0] p2_white_left;
  logic lead_black;
  logic [CW-1:0] p1_card;
  logic [CW-1:0] p2_card;
  logic [1:0] last_result;
  logic game_over;
  logic [1:0] game_result;
  logic err;
  modport master (
    output btn_confirm, btn_abort, sw,
    input state, round, p1_wins, p2_wins, lead, p1_used, p2_used,
    input p1_black_left, p1_white_left, p2_black_left, p2_white_left,
    input lead_black, p1_card, p2_card, last_result, game_over, game_result, err
  );
  modport slave (
    input btn_confirm, btn_abort, sw,
    output state, round, p1_wins, p2_wins, lead, p1_used, p2_used,
    output p1_black_left, p1_white_left, p2_black_left, p2_white_left,
    output lead_black, p1_card, p2_card, last_result, game_over, game_result, err
  );
endinterface

// File: rtl/baw_match_engine.sv
// baw_match_engine: black-and-white bidding game match controller
module baw_match_engine #(
  parameter int NCARD = 9,
  parameter int NROUND = NCARD
) (
  input logic clk,
  input logic reset_n,
  baw_match_if.slave bus
);
  localparam int CW = $clog2(NCARD);
  localparam int RW = $clog2(NROUND + 1);
  localparam int KW = CW + 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROUND_SHOW = 3'd1,
    LEAD_PICK = 3'd2,
    FOLLOW_PICK = 3'd3,
    RESULT = 3'd4,
    GAME_END = 3'd5
  } state_t;
  typedef struct packed {
    state_t st;
    logic [RW-1:0] round;
    logic [RW-1:0] p1_wins;
    logic [RW-1:0] p2_wins;
    logic lead;
    logic [NCARD-1:0] p1_used;
    logic [NCARD-1:0] p2_used;
    logic lead_black;
    logic [CW-1:0] p1_card;
    logic [CW-1:0] p2_card;
    logic [1:0] last_result;
    logic game_over;
    logic [1:0] game_result;
    logic err;
  } regs_t;
  regs_t r, n;
  logic conf_prev, abort_prev;
  logic conf, abrt;
  logic [CW-1:0] sel;
  logic one_hot, picker_p2, pick_ok, finish;
  logic [CW-1:0] p1v, p2v;
  logic [NCARD-1:0] picker_used;
  int margin;
  // Prev registers reset high so a button held through reset release needs a fresh press
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r <= '0;
      conf_prev <= 1'b1;
      abort_prev <= 1'b1;
    end else begin
      r <= n;
      conf_prev <= bus.btn_confirm;
      abort_prev <= bus.btn_abort;
    end
  assign conf = bus.btn_confirm & ~conf_prev;
  assign abrt = bus.btn_abort & ~abort_prev;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NCARD; i++)
      if (bus.sw[i]) sel = CW'(i);
  end
  assign one_hot = (bus.sw != '0) && ((bus.sw & (bus.sw - 1'b1)) == '0);
  // The leader picks in LEAD_PICK, the other player in FOLLOW_PICK
  assign picker_p2 = r.lead ^ (r.st == FOLLOW_PICK);
  assign picker_used = picker_p2 ? r.p2_used : r.p1_used;
  assign pick_ok = one_hot && ((bus.sw & picker_used) == '0);
  assign p1v = picker_p2 ? r.p1_card : sel;
  assign p2v = picker_p2 ? sel : r.p2_card;
  assign margin = int'(r.p1_wins) > int'(r.p2_wins) ? int'(r.p1_wins) - int'(r.p2_wins)
                                                    : int'(r.p2_wins) - int'(r.p1_wins);
  assign finish = (r.round == RW'(NROUND)) || (margin > NROUND - int'(r.round));
  always_comb begin
    n = r;
    n.err = 1'b0;
    if (abrt && r.st != IDLE)
      n = '0;
    else if (conf)
      case (r.st)
        IDLE: begin
          n = '0;
          n.st = ROUND_SHOW;
          n.round = RW'(1);
        end
        ROUND_SHOW: n.st = LEAD_PICK;
        LEAD_PICK, FOLLOW_PICK:
          if (!pick_ok)
            n.err = 1'b1;
          else begin
            if (picker_p2) begin
              n.p2_card = sel;
              n.p2_used = r.p2_used | bus.sw;
            end else begin
              n.p1_card = sel;
              n.p1_used = r.p1_used | bus.sw;
            end
            if (r.st == LEAD_PICK) begin
              n.st = FOLLOW_PICK;
              n.lead_black = sel[0];
            end else begin
              n.st = RESULT;
              n.last_result = p1v > p2v ? 2'b01 : p1v < p2v ? 2'b10 : 2'b11;
              n.p1_wins = r.p1_wins + RW'(p1v > p2v);
              n.p2_wins = r.p2_wins + RW'(p1v < p2v);
            end
          end
        RESULT:
          if (finish) begin
            n.st = GAME_END;
            n.game_over = 1'b1;
            n.game_result = r.p1_wins > r.p2_wins ? 2'b01 : r.p1_wins < r.p2_wins ? 2'b10 : 2'b11;
          end else begin
            n.st = ROUND_SHOW;
            n.round = r.round + 1'b1;
            n.lead = r.last_result == 2'b01 ? 1'b0 : r.last_result == 2'b10 ? 1'b1 : r.lead;
            n.lead_black = 1'b0;
            n.p1_card = '0;
            n.p2_card = '0;
          end
        GAME_END: n = '0;
        default: ;
      endcase
  end
  always_comb begin
    bus.p1_black_left = '0;
    bus.p1_white_left = '0;
    bus.p2_black_left = '0;
    bus.p2_white_left = '0;
    for (int i = 0; i < NCARD; i++)
      if (i % 2 == 1) begin
        bus.p1_black_left = bus.p1_black_left + KW'(!r.p1_used[i]);
        bus.p2_black_left = bus.p2_black_left + KW'(!r.p2_used[i]);
      end else begin
        bus.p1_white_left = bus.p1_white_left + KW'(!r.p1_used[i]);
        bus.p2_white_left = bus.p2_white_left + KW'(!r.p2_used[i]);
      end
  end
  assign bus.state = r.st;
  assign bus.round = r.round;
  assign bus.p1_wins = r.p1_wins;
  assign bus.p2_wins = r.p2_wins;
  assign bus.lead = r.lead;
  assign bus.p1_used = r.p1_used;
  assign bus.p2_used = r.p2_used;
  assign bus.lead_black = r.lead_black;
  assign bus.p1_card = (r.st == RESULT || r.st == GAME_END) ? r.p1_card : '0;
  assign bus.p2_card = (r.st == RESULT || r.st == GAME_END) ? r.p2_card : '0;
  assign bus.last_result = r.last_result;
  assign bus.game_over = r.game_over;
  assign bus.game_result = r.game_result;
  assign bus.err = r.err;
endmodule

// File: tb/tb_baw_match_engine.sv
// tb_baw_match_engine: directed match sequences with hand-computed expectations
module tb_baw_match_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  baw_match_if #(.NCARD(9), .NROUND(9)) bus ();
  baw_match_engine #(.NCARD(9), .NROUND(9)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press();
    @(negedge clk) bus.btn_confirm = 1'b1;
    @(negedge clk) bus.btn_confirm = 1'b0;
  endtask
  task automatic play(input int v);
    bus.sw = '0;
    bus.sw[v] = 1'b1;
    press();
  endtask
  initial begin
    bus.btn_confirm = 1'b0;
    bus.btn_abort = 1'b0;
    bus.sw = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_round", bus.round, 0);
    chk("rst_p1_black", bus.p1_black_left, 4);
    chk("rst_p1_white", bus.p1_white_left, 5);
    chk("rst_p2_black", bus.p2_black_left, 4);
    chk("rst_err", bus.err, 0);
    chk("rst_game_over", bus.game_over, 0);
    press();
    chk("show_state", bus.state, 1);
    chk("show_round", bus.round, 1);
    chk("show_lead", bus.lead, 0);
    press();
    chk("lead_state", bus.state, 2);
    bus.sw = 9'b000000011;
    press();
    chk("two_hot_err", bus.err, 1);
    chk("two_hot_state", bus.state, 2);
    @(negedge clk);
    chk("err_one_cycle", bus.err, 0);
    bus.sw = '0;
    press();
    chk("zero_err", bus.err, 1);
    @(negedge clk);
    chk("zero_err_drop", bus.err, 0);
    chk("zero_no_mask", bus.p1_used, 0);
    bus.sw = 9'h080;
    @(negedge clk) bus.btn_confirm = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_confirm = 1'b0;
    @(negedge clk);
    chk("hold_state", bus.state, 3);
    chk("hold_p1_used", bus.p1_used, 9'h080);
    chk("hold_lead_black", bus.lead_black, 1);
    chk("hold_p1_black", bus.p1_black_left, 3);
    chk("hold_card_hidden", bus.p1_card, 0);
    play(3);
    chk("r1_state", bus.state, 4);
    chk("r1_result", bus.last_result, 2'b01);
    chk("r1_p1_wins", bus.p1_wins, 1);
    chk("r1_p2_wins", bus.p2_wins, 0);
    chk("r1_p1_card", bus.p1_card, 7);
    chk("r1_p2_card", bus.p2_card, 3);
    chk("r1_p2_black", bus.p2_black_left, 3);
    press();
    chk("r2_state", bus.state, 1);
    chk("r2_round", bus.round, 2);
    chk("r2_lead", bus.lead, 0);
    chk("r2_lead_black", bus.lead_black, 0);
    press();
    play(2);
    chk("r2_lead_white", bus.lead_black, 0);
    play(1);
    chk("r2_result", bus.last_result, 2'b01);
    chk("r2_p1_wins", bus.p1_wins, 2);
    press();
    chk("r3_round", bus.round, 3);
    press();
    play(2);
    chk("reuse_err", bus.err, 1);
    chk("reuse_state", bus.state, 2);
    play(4);
    play(6);
    chk("r3_result", bus.last_result, 2'b10);
    chk("r3_p2_wins", bus.p2_wins, 1);
    press();
    chk("r4_round", bus.round, 4);
    chk("r4_lead", bus.lead, 1);
    press();
    play(8);
    chk("r4_p2_used", bus.p2_used, 9'h14A);
    play(8);
    chk("tie_result", bus.last_result, 2'b11);
    chk("tie_p1_wins", bus.p1_wins, 2);
    chk("tie_p2_wins", bus.p2_wins, 1);
    chk("tie_p1_card", bus.p1_card, 8);
    press();
    chk("r5_round", bus.round, 5);
    chk("r5_lead_kept", bus.lead, 1);
    press();
    play(0);
    chk("r5_follow", bus.state, 3);
    @(negedge clk) begin bus.btn_abort = 1'b1; bus.btn_confirm = 1'b1; end
    @(negedge clk) begin bus.btn_abort = 1'b0; bus.btn_confirm = 1'b0; end
    chk("abort_state", bus.state, 0);
    chk("abort_round", bus.round, 0);
    chk("abort_p1_wins", bus.p1_wins, 0);
    chk("abort_p2_wins", bus.p2_wins, 0);
    chk("abort_p1_used", bus.p1_used, 0);
    chk("abort_p2_used", bus.p2_used, 0);
    chk("abort_result", bus.last_result, 0);
    chk("abort_p2_black", bus.p2_black_left, 4);
    press();
    for (int k = 0; k < 5; k++) begin
      press();
      play(8 - k);
      play(7 - k);
      chk("b_result", bus.last_result, 2'b01);
      chk("b_p1_wins", bus.p1_wins, k + 1);
      press();
      if (k < 4) begin
        chk("b_state", bus.state, 1);
        chk("b_round", bus.round, k + 2);
      end
    end
    chk("end_state", bus.state, 5);
    chk("end_game_over", bus.game_over, 1);
    chk("end_game_result", bus.game_result, 2'b01);
    chk("end_round", bus.round, 5);
    chk("end_p1_card", bus.p1_card, 4);
    chk("end_p2_card", bus.p2_card, 3);
    press();
    chk("end_idle", bus.state, 0);
    chk("end_cleared", bus.game_over, 0);
    chk("end_round_clr", bus.round, 0);
    press();
    chk("c_show", bus.state, 1);
    @(negedge clk) bus.btn_confirm = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    chk("async_state", bus.state, 0);
    chk("async_round", bus.round, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_no_act", bus.state, 0);
    bus.btn_confirm = 1'b0;
    press();
    chk("fresh_press", bus.state, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
